// File: rtl/rf_access_arbiter.sv
// Round-robin arbiter sharing one register-file port between the frame path (0) and config/debug path (1).
// Optional read timeout is built when RF_ARB_READ_TIMEOUT_EN is defined.
module rf_access_arbiter #(
    parameter int WIDTH_REG = 8,
    parameter int ADDR      = 4,
    parameter int TMO_CYC   = 15
) (
    input  logic                 i_Ref_clk,
    input  logic                 i_rst,
    input  logic                 i_req0,
    input  logic                 i_req1,
    input  logic                 i_wr0,
    input  logic                 i_wr1,
    input  logic [ADDR-1:0]      i_addr0,
    input  logic [ADDR-1:0]      i_addr1,
    input  logic [WIDTH_REG-1:0] i_wdata0,
    input  logic [WIDTH_REG-1:0] i_wdata1,
    output logic                 o_ack0,
    output logic                 o_ack1,
    output logic [WIDTH_REG-1:0] o_rd_data,
    output logic                 o_rd_err,
    output logic                 o_busy,
    output logic                 o_owner,
    output logic                 o_wr_en,
    output logic                 o_rd_en,
    output logic [ADDR-1:0]      o_adder,
    output logic [WIDTH_REG-1:0] o_Wr_D_REG,
    input  logic [WIDTH_REG-1:0] i_Rd_D_REG,
    input  logic                 i_Vid_Rd
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    state_t               state;
    logic                 rr_ptr;
    logic                 owner;
    logic                 lat_wr;
    logic [ADDR-1:0]      lat_addr;
    logic [WIDTH_REG-1:0] lat_wdata;
    logic [WIDTH_REG-1:0] rd_data;
    logic                 rd_err;
    logic                 grant_valid;
    logic                 grant_sel;
    logic                 tmo_hit;

    // A lone requester always wins; the RR pointer only breaks ties.
    always_comb begin
        grant_valid = i_req0 | i_req1;
        if (i_req0 && i_req1) begin
            grant_sel = rr_ptr;
        end else begin
            grant_sel = i_req1;
        end
    end

`ifdef RF_ARB_READ_TIMEOUT_EN
    localparam int CW = $clog2(TMO_CYC);

    logic [CW-1:0] tmo_cnt;

    // Counter sits at zero outside READ, so entry into READ starts from the first cycle.
    always_ff @(posedge i_Ref_clk or negedge i_rst) begin
        if (!i_rst) begin
            tmo_cnt <= '0;
        end else if (state == READ) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_hit = (tmo_cnt == CW'(TMO_CYC - 1));
`else
    // TMO_CYC stays referenced so the parameter list is identical in both builds.
    assign tmo_hit = 1'b0 & (TMO_CYC < 2);
`endif

    always_ff @(posedge i_Ref_clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            owner     <= 1'b0;
            lat_wr    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rd_data   <= '0;
            rd_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner     <= grant_sel;
                        lat_wr    <= grant_sel ? i_wr1 : i_wr0;
                        lat_addr  <= grant_sel ? i_addr1 : i_addr0;
                        lat_wdata <= grant_sel ? i_wdata1 : i_wdata0;
                        state     <= (grant_sel ? i_wr1 : i_wr0) ? WRITE : READ;
                    end
                end
                WRITE: begin
                    rr_ptr <= ~owner;
                    state  <= IDLE;
                end
                READ: begin
                    // Valid data beats a simultaneous timeout.
                    if (i_Vid_Rd) begin
                        rd_data <= i_Rd_D_REG;
                        rd_err  <= 1'b0;
                        state   <= RESP;
                    end else if (tmo_hit) begin
                        rd_data <= '0;
                        rd_err  <= 1'b1;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    rr_ptr <= ~owner;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_busy     = (state != IDLE);
    assign o_owner    = owner;
    assign o_wr_en    = (state == WRITE);
    assign o_rd_en    = (state == READ);
    assign o_ack0     = ((state == WRITE) || (state == RESP)) && !owner;
    assign o_ack1     = ((state == WRITE) || (state == RESP)) && owner;
    assign o_adder    = lat_addr;
    assign o_Wr_D_REG = lat_wdata;
    assign o_rd_data  = rd_data;
    assign o_rd_err   = rd_err;

    logic unused_lat_wr;
    assign unused_lat_wr = lat_wr;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Bench for rf_access_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Timeout scenarios are included when RF_ARB_READ_TIMEOUT_EN is defined.
module tb_rf_access_arbiter;

    localparam int WIDTH_REG = 8;
    localparam int ADDR      = 4;
    localparam int TMO_CYC   = 15;
`ifdef RF_ARB_READ_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic                 ref_clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 req0 = 1'b0, req1 = 1'b0;
    logic                 wr0 = 1'b0, wr1 = 1'b0;
    logic [ADDR-1:0]      addr0 = '0, addr1 = '0;
    logic [WIDTH_REG-1:0] wdata0 = '0, wdata1 = '0;
    logic [WIDTH_REG-1:0] rdd = '0;
    logic                 vid = 1'b0;
    logic                 ack0, ack1, rd_err, busy, owner, wr_en, rd_en;
    logic [WIDTH_REG-1:0] rd_data, wdata_out;
    logic [ADDR-1:0]      adder;

    int checks = 0;
    int errors = 0;

    always #5 ref_clk = ~ref_clk;

    rf_access_arbiter #(.WIDTH_REG(WIDTH_REG), .ADDR(ADDR), .TMO_CYC(TMO_CYC)) dut (
        .i_Ref_clk(ref_clk), .i_rst(rst),
        .i_req0(req0), .i_req1(req1), .i_wr0(wr0), .i_wr1(wr1),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_ack0(ack0), .o_ack1(ack1), .o_rd_data(rd_data), .o_rd_err(rd_err),
        .o_busy(busy), .o_owner(owner), .o_wr_en(wr_en), .o_rd_en(rd_en),
        .o_adder(adder), .o_Wr_D_REG(wdata_out), .i_Rd_D_REG(rdd), .i_Vid_Rd(vid)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one access in flight, described by who owns it and how far it has got.
    bit                   started = 1'b0;
    bit                   m_busy = 1'b0, m_rr = 1'b0, m_owner = 1'b0, m_wr = 1'b0, m_resp = 1'b0, m_rerr = 1'b0;
    int                   m_rcnt = 0;
    logic [ADDR-1:0]      m_addr = '0;
    logic [WIDTH_REG-1:0] m_wdata = '0, m_rdata = '0;

    task automatic model_step();
        bit pick;
        if (!rst) begin
            m_busy = 0; m_rr = 0; m_owner = 0; m_wr = 0; m_resp = 0; m_rerr = 0;
            m_rcnt = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
            return;
        end
        if (!m_busy) begin
            if (req0 || req1) begin
                pick    = (req0 && req1) ? m_rr : req1;
                m_owner = pick;
                m_wr    = pick ? wr1 : wr0;
                m_addr  = pick ? addr1 : addr0;
                m_wdata = pick ? wdata1 : wdata0;
                m_busy  = 1; m_resp = 0; m_rcnt = 0;
            end
        end else if (m_wr || m_resp) begin
            m_busy = 0;
            m_rr   = !m_owner;
        end else begin
            m_rcnt++;
            if (vid) begin
                m_rdata = rdd; m_rerr = 0; m_resp = 1;
            end else if (TIMEOUT_ON && m_rcnt == TMO_CYC) begin
                m_rdata = '0; m_rerr = 1; m_resp = 1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge ref_clk);
            model_step();
            started = 1'b1;
        end
    end

    // Single compare process, mid-cycle.
    always @(negedge ref_clk) begin
        if (started) begin
            if (!rst) begin
                check_output("rst_busy", busy, 0);
                check_output("rst_wr_en", wr_en, 0);
                check_output("rst_rd_en", rd_en, 0);
                check_output("rst_ack0", ack0, 0);
                check_output("rst_ack1", ack1, 0);
                check_output("rst_owner", owner, 0);
                check_output("rst_rd_data", rd_data, 0);
                check_output("rst_rd_err", rd_err, 0);
            end else begin
                check_output("busy", busy, m_busy);
                check_output("wr_en", wr_en, m_busy && m_wr);
                check_output("rd_en", rd_en, m_busy && !m_wr && !m_resp);
                check_output("ack0", ack0, m_busy && (m_wr || m_resp) && !m_owner);
                check_output("ack1", ack1, m_busy && (m_wr || m_resp) && m_owner);
                check_output("owner", owner, m_owner);
                check_output("rd_data", rd_data, m_rdata);
                check_output("rd_err", rd_err, m_rerr);
                if (m_busy && !m_resp) check_output("adder", adder, m_addr);
                if (m_busy && m_wr) check_output("wdata", wdata_out, m_wdata);
            end
        end
    end

    task automatic tick();
        @(posedge ref_clk);
        #1;
    endtask

    task automatic apply_stimulus_write(input bit who, input logic [ADDR-1:0] a, input logic [WIDTH_REG-1:0] d);
        if (who) begin req1 = 1; wr1 = 1; addr1 = a; wdata1 = d; end
        else begin req0 = 1; wr0 = 1; addr0 = a; wdata0 = d; end
        tick();
        check_output("wr_strobe", wr_en, 1);
        check_output("wr_addr", adder, a);
        check_output("wr_data", wdata_out, d);
        check_output("wr_ack_owner", who ? ack1 : ack0, 1);
        check_output("wr_ack_other", who ? ack0 : ack1, 0);
        check_output("wr_no_rd_en", rd_en, 0);
        tick();
        if (who) req1 = 0; else req0 = 0;
        check_output("wr_one_cycle", wr_en, 0);
        tick();
    endtask

    task automatic run_contention();
        int n;
        bit exp_owner;
        rst = 0;
        req0 = 1; wr0 = 1; addr0 = 4'h1; wdata0 = 8'h11;
        req1 = 1; wr1 = 1; addr1 = 4'hE; wdata1 = 8'hEE;
        tick(); tick();
        rst = 1;
        n = 0;
        for (int i = 0; i < 40 && n < 8; i++) begin
            tick();
            if (ack0 || ack1) begin
                exp_owner = n[0];
                check_output("cont_two_acks", ack0 && ack1, 0);
                check_output("cont_owner", owner, exp_owner);
                check_output("cont_ack1", ack1, exp_owner);
                check_output("cont_addr", adder, exp_owner ? 4'hE : 4'h1);
                n++;
                if (n == 8) begin req0 = 0; req1 = 0; end
            end else begin
                check_output("cont_idle_gap", busy, 0);
            end
        end
        check_output("cont_grant_count", n, 8);
        tick(); tick();
    endtask

`ifdef RF_ARB_READ_TIMEOUT_EN
    task automatic run_timeout();
        int n;
        bit got;
        req0 = 1; wr0 = 0; addr0 = 4'h7;
        n = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (ack0) got = 1;
            else if (rd_en) n++;
        end
        check_output("tmo_ack_seen", got, 1);
        check_output("tmo_read_cycles", n, 15);
        check_output("tmo_err", rd_err, 1);
        check_output("tmo_data", rd_data, 0);
        tick();
        req0 = 0;
        tick();
        req0 = 1; addr0 = 4'h8;
        n = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            vid = 0;
            if (ack0) got = 1;
            else if (rd_en) begin
                n++;
                if (n == 15) begin vid = 1; rdd = 8'h5A; end
            end
        end
        check_output("tmo_edge_ack_seen", got, 1);
        check_output("tmo_edge_cycles", n, 15);
        check_output("tmo_edge_err", rd_err, 0);
        check_output("tmo_edge_data", rd_data, 8'h5A);
        tick();
        req0 = 0;
        tick();
    endtask
`endif

    task automatic run_random(input int cycles, input bit allow_new);
        bit pa0, pa1;
        pa0 = 0; pa1 = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (pa0) req0 = 0;
            else if (!req0 && allow_new && $urandom_range(2) == 0) begin
                req0 = 1; wr0 = $urandom_range(1); addr0 = ADDR'($urandom); wdata0 = WIDTH_REG'($urandom);
            end else if (req0 && $urandom_range(3) == 0) begin
                addr0 = ADDR'($urandom); wdata0 = WIDTH_REG'($urandom); wr0 = $urandom_range(1);
            end
            if (pa1) req1 = 0;
            else if (!req1 && allow_new && $urandom_range(2) == 0) begin
                req1 = 1; wr1 = $urandom_range(1); addr1 = ADDR'($urandom); wdata1 = WIDTH_REG'($urandom);
            end else if (req1 && $urandom_range(3) == 0) begin
                addr1 = ADDR'($urandom); wdata1 = WIDTH_REG'($urandom); wr1 = $urandom_range(1);
            end
            vid = ($urandom_range(3) == 0);
            rdd = WIDTH_REG'($urandom);
            pa0 = ack0;
            pa1 = ack1;
            if (!allow_new && !req0 && !req1 && !busy) break;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tick(); tick();
        check_output("reset_busy", busy, 0);
        check_output("reset_rd_data", rd_data, 0);
        check_output("reset_acks", {ack0, ack1}, 0);
        rst = 1;
        tick();

        $display("[TB] write from requester 0");
        apply_stimulus_write(0, 4'h5, 8'h3C);

        $display("[TB] read from requester 1");
        req1 = 1; wr1 = 0; addr1 = 4'h2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("rd_wait_en", rd_en, 1);
            check_output("rd_wait_addr", adder, 4'h2);
            check_output("rd_wait_noack", ack1, 0);
        end
        vid = 1; rdd = 8'hA7;
        tick();
        vid = 0;
        check_output("rd_ack1", ack1, 1);
        check_output("rd_data_a7", rd_data, 8'hA7);
        check_output("rd_err_clear", rd_err, 0);
        check_output("rd_en_off", rd_en, 0);
        tick();
        req1 = 0;
        tick();

        $display("[TB] contention");
        run_contention();

`ifdef RF_ARB_READ_TIMEOUT_EN
        $display("[TB] read timeout");
        run_timeout();
`endif

        $display("[TB] reset during read");
        req1 = 1; wr1 = 0; addr1 = 4'h9;
        tick(); tick();
        check_output("mid_rd_en", rd_en, 1);
        #2;
        rst = 0;
        #1;
        check_output("async_rd_en", rd_en, 0);
        check_output("async_busy", busy, 0);
        check_output("async_rd_data", rd_data, 0);
        check_output("async_adder", adder, 0);
        tick();
        req1 = 0;
        tick();
        rst = 1;
        tick();
        req1 = 1; addr1 = 4'h3;
        tick();
        check_output("post_rst_rd_en", rd_en, 1);
        vid = 1; rdd = 8'hC3;
        tick();
        vid = 0;
        check_output("post_rst_ack1", ack1, 1);
        check_output("post_rst_data", rd_data, 8'hC3);
        tick();
        req1 = 0;
        tick();

        $display("[TB] stray valid while idle");
        vid = 1; rdd = 8'hFF;
        tick();
        vid = 0;
        tick();
        check_output("stray_keep_data", rd_data, 8'hC3);
        apply_stimulus_write(0, 4'hF, 8'h81);
        apply_stimulus_write(1, 4'h0, 8'h42);
        check_output("stray_data_after_wr", rd_data, 8'hC3);

        $display("[TB] random traffic");
        run_random(600, 1'b1);
        run_random(300, 1'b0);
        vid = 0;
        check_output("drain_idle", busy || req0 || req1, 0);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_access_arbiter.md
Name: rf_access_arbiter

Overview:
Shares the single register-file port between two requesters: requester 0 is the system-control frame path and requester 1 is the configuration/debug path. It grants one access at a time using round-robin priority and drives the register file's write-enable, read-enable, address and write-data signals. It waits for the register file's read-valid signal and returns the read data with a per-requester acknowledge. It sits between the requesters and the register file, in the reference-clock domain.

Parameters:
WIDTH_REG, 8, data width of the register file
ADDR, 4, register-file address width
TMO_CYC, 15, read-timeout limit in cycles (used only with the optional feature; must be >= 2)

Ports:
i_Ref_clk  input  1  reference clock, rising edge
i_rst  input  1  asynchronous active-low reset
i_req0 / i_req1  input  1  access request, held until the matching ack
i_wr0 / i_wr1  input  1  1 = write, 0 = read; valid while req is high
i_addr0 / i_addr1  input  ADDR  target register
i_wdata0 / i_wdata1  input  WIDTH_REG  write data
o_ack0 / o_ack1  output  1  one-cycle completion pulse for the owning requester
o_rd_data  output  WIDTH_REG  read result, valid when ack is high for a read
o_rd_err  output  1  read timed out; valid with ack
o_busy  output  1  an access is in progress (state != IDLE)
o_owner  output  1  index of the current or last granted requester
o_wr_en  output  1  register-file write strobe
o_rd_en  output  1  register-file read enable
o_adder  output  ADDR  register-file address
o_Wr_D_REG  output  WIDTH_REG  register-file write data
i_Rd_D_REG  input  WIDTH_REG  register-file read data
i_Vid_Rd  input  1  register-file read data valid

Behaviour:
- Reset (i_rst low, asynchronous): state IDLE, RR pointer=0, owner=0, latched addr/data/wr=0, o_rd_data=0, o_rd_err=0. All strobes and acks are 0. A reset during any access aborts it and no ack is issued.
- State machine has four states: IDLE, WRITE, READ, RESP. All outputs depend only on the state and internal registers (Moore); no combinational path from req to any output.
- IDLE:
  - Only one request high: grant it.
  - Both high: grant the requester the RR pointer names.
  - On grant, latch owner, addr, wdata and wr; next state is WRITE if wr=1, otherwise READ.
  - Requests are sampled only in IDLE. Changing addr, data or wr after grant has no effect.
- WRITE (1 cycle):
  - o_wr_en=1, o_adder=latched addr, o_Wr_D_REG=latched data.
  - o_ack[owner]=1.
  - RR pointer becomes the other requester; next state IDLE.
- READ:
  - o_rd_en=1 and o_adder=latched addr, held for every READ cycle.
  - When i_Vid_Rd=1: capture i_Rd_D_REG into o_rd_data, clear o_rd_err, go to RESP.
  - Otherwise stay in READ.
- RESP (1 cycle):
  - o_ack[owner]=1, with o_rd_data and o_rd_err valid.
  - RR pointer becomes the other requester; next state IDLE.
- o_rd_data and o_rd_err hold their values until the next read completes.
- Latency:
  - Write: request seen at edge N; o_wr_en and ack are high during cycle N+1.
  - Read: ack one cycle after the cycle in which i_Vid_Rd is sampled high.
- Handshake:
  - A requester deasserts req in the cycle after it samples ack.
  - The arbiter spends at least one IDLE cycle between accesses, so a registered requester is never double-granted.
  - A requester that keeps req high after its ack is served again only by RR order.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1.
- The o_wr_en and o_rd_en strobes are never high together. At most one ack is high in any cycle.
- A pulse on i_Vid_Rd outside the READ state is ignored.
- Writes to address 0 and address 2^ADDR-1 pass through unchanged; the block does no address checking.

Optional Feature:
RF_ARB_READ_TIMEOUT_EN
- Defined:
  - A counter clears on entry to READ and increments each READ cycle.
  - If i_Vid_Rd is still low in the TMO_CYC-th READ cycle: o_rd_data=0, o_rd_err=1, go to RESP.
  - If i_Vid_Rd and expiry occur in the same cycle, the data wins and o_rd_err=0.
- Not defined: no counter is built, o_rd_err is tied to 0, and READ waits indefinitely.

Test Plan:
1. Write, requester 0: req0, wr0=1, addr0=4'h5, wdata0=8'h3C.
   Required: o_wr_en=1, o_adder=5, o_Wr_D_REG=8'h3C for exactly one cycle, ack0 in that same cycle, o_rd_en stays 0.
2. Read, requester 1: req1, wr1=0, addr1=4'h2; bench drives i_Vid_Rd after 3 cycles with i_Rd_D_REG=8'hA7.
   Required: o_rd_en high for the whole wait, then ack1 the next cycle with o_rd_data=8'hA7 and o_rd_err=0; ack0 never asserts.
3. Contention: req0 and req1 held high from reset, both writes.
   Required: grant order 0,1,0,1, o_owner toggles each access, an IDLE cycle between accesses, never two acks at once.
4. Timeout (macro on, TMO_CYC=15): read with i_Vid_Rd never asserted.
   Required: ack after 15 READ cycles plus the RESP cycle, with o_rd_err=1 and o_rd_data=0. Repeat with i_Vid_Rd=1 in the 15th cycle: o_rd_err=0 and data is captured.
5. Reset mid-read: assert i_rst low while in READ.
   Required: all outputs 0 asynchronously, no ack; after release a new read from requester 1 completes normally.
6. Stray valid: pulse i_Vid_Rd while IDLE, then start a write.
   Required: o_rd_data unchanged, write completes normally.
